// File: rtl/doppio_pkg.sv
// Shared types and helpers for the Doppio return path (lane_dispatcher).
//   N_LANES / DATA_W : default lane count and word width
//   lane_idx_t       : lane number
//   disp_state_t     : lane-selection mode (SEQ rotation / RND lfsr pick)
//   lfsr_next()      : 4-bit LFSR step, period 15
//   lane_to_leds()   : thermometer code {LED_2, LED_1, LED_0} for a lane
package doppio_pkg;

    localparam int N_LANES = 4;
    localparam int DATA_W  = 64;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic {
        SEQ = 1'b0,
        RND = 1'b1
    } disp_state_t;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    function automatic logic [2:0] lane_to_leds(input lane_idx_t lane);
        logic [2:0] leds;
        case (lane)
            2'd0:    leds = 3'b000;
            2'd1:    leds = 3'b001;
            2'd2:    leds = 3'b011;
            default: leds = 3'b111;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane buffer for lane_dispatcher.
//   clk, rst_n : clock, async active-low reset (flushes contents, clears storage)
//   push/data  : write request; ignored while full
//   pop        : read request; ignored while empty
//   head       : registered word at the read pointer (stale when empty)
//   full/empty : occupancy flags, from registered pointers only
module lane_fifo #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [0:DATA_W-1] push_data,
    input  logic              pop,
    output logic [0:DATA_W-1] head,
    output logic              full,
    output logic              empty
);
    import doppio_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [0:DATA_W-1] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/lane_dispatcher.sv
// Return-path demultiplexer: one valid/ready input stream fanned out to four
// lane FIFOs. The target lane rotates 0,1,2,3 every DWELL cycles, or takes an
// LFSR-random pick at each dwell expiry while D_OFF is high.
//   D_CLK, D_RST_N       : clock, async active-low reset (flushes all lanes)
//   D_OFF                : 1 = random lane choice, 0 = rotation (sampled at expiry)
//   IN_DATA/VALID/READY  : input stream; READY = current lane not full
//   OUT_DATA/VALID/READY : per-lane FIFO head and handshake
//   CUR_LANE             : selected lane
//   LED_0..LED_2         : thermometer display of CUR_LANE
module lane_dispatcher #(
    parameter int         N_LANES    = 4,
    parameter int         DATA_W     = 64,
    parameter int         DWELL      = 10000000,
    parameter int         FIFO_DEPTH = 2,
    parameter logic [3:0] LFSR_SEED  = 4'b1101
) (
    input  logic                             D_CLK,
    input  logic                             D_RST_N,
    input  logic                             D_OFF,
    input  logic [0:DATA_W-1]                IN_DATA,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    output logic [N_LANES-1:0][0:DATA_W-1]   OUT_DATA,
    output logic [N_LANES-1:0]               OUT_VALID,
    input  logic [N_LANES-1:0]               OUT_READY,
    output logic [1:0]                       CUR_LANE,
    output logic                             LED_0,
    output logic                             LED_1,
    output logic                             LED_2
);
    import doppio_pkg::*;

    localparam int CW = $clog2(DWELL + 1);

    disp_state_t        state, state_nxt;
    lane_idx_t          cur_lane, lane_nxt;
    logic [3:0]         lfsr;
    logic [CW-1:0]      dwell_cnt;
    logic               expiry;
    logic               accept;
    logic [N_LANES-1:0] full;
    logic [N_LANES-1:0] empty;

    assign expiry = (dwell_cnt == CW'(DWELL - 1));

    // Ready is forced low during reset so nothing upstream sees a false accept
    // while the FIFOs are being flushed.
    assign IN_READY = D_RST_N && !full[cur_lane];
    assign accept   = IN_VALID && IN_READY;

    always_ff @(posedge D_CLK or negedge D_RST_N) begin
        if (!D_RST_N) begin
            dwell_cnt <= '0;
            lfsr      <= LFSR_SEED;
        end else begin
            dwell_cnt <= expiry ? '0 : dwell_cnt + CW'(1);
            lfsr      <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge D_CLK or negedge D_RST_N) begin
        if (!D_RST_N) begin
            state    <= SEQ;
            cur_lane <= '0;
        end else begin
            state    <= state_nxt;
            cur_lane <= lane_nxt;
        end
    end

    // Mode and lane only move at expiry; D_OFF is a don't-care in between.
    always_comb begin
        state_nxt = state;
        lane_nxt  = cur_lane;
        if (expiry) begin
            if (D_OFF) begin
                state_nxt = RND;
                lane_nxt  = lfsr[2:1];
            end else begin
                state_nxt = SEQ;
                lane_nxt  = (state == SEQ) ? cur_lane + 2'd1 : 2'd0;
            end
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        lane_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (D_CLK),
            .rst_n     (D_RST_N),
            .push      (accept && (cur_lane == lane_idx_t'(i))),
            .push_data (IN_DATA),
            .pop       (OUT_READY[i]),
            .head      (OUT_DATA[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
        assign OUT_VALID[i] = !empty[i];
    end

    assign CUR_LANE              = cur_lane;
    assign {LED_2, LED_1, LED_0} = lane_to_leds(cur_lane);

endmodule

// File: tb/tb_lane_dispatcher.sv
module tb_lane_dispatcher;

    localparam int DWELL = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             d_off = 1'b0;
    logic [0:63]      in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0][0:63] out_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready = '0;
    logic [1:0]       cur_lane;
    logic             led0, led1, led2;

    int errors = 0;
    int checks = 0;

    lane_dispatcher #(
        .N_LANES (4), .DATA_W (64), .DWELL (DWELL), .FIFO_DEPTH (DEPTH), .LFSR_SEED (4'b1101)
    ) dut (
        .D_CLK (clk), .D_RST_N (rst_n), .D_OFF (d_off),
        .IN_DATA (in_data), .IN_VALID (in_valid), .IN_READY (in_ready),
        .OUT_DATA (out_data), .OUT_VALID (out_valid), .OUT_READY (out_ready),
        .CUR_LANE (cur_lane), .LED_0 (led0), .LED_1 (led1), .LED_2 (led2)
    );

    always #5 clk = ~clk;

    // Reference model: per-lane queues, elapsed-cycle count, golden LFSR.
    logic [63:0] q [4][$];
    int          m_lane;
    int          m_cyc;
    bit          m_rnd;
    logic [3:0]  m_lfsr;
    logic [2:0]  led_tab [4] = '{3'b000, 3'b001, 3'b011, 3'b111};

    function automatic logic [3:0] m_valid();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (q[i].size() > 0);
        return v;
    endfunction

    function automatic logic m_ready();
        return q[m_lane].size() < DEPTH;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        m_lane = 0;
        m_cyc  = 0;
        m_rnd  = 1'b0;
        m_lfsr = 4'b1101;
    endtask

    // Applies one clock edge of the spec's rules to the model.
    task automatic adv();
        bit acc;
        acc = in_valid && (q[m_lane].size() < DEPTH);
        for (int i = 0; i < 4; i++)
            if (q[i].size() > 0 && out_ready[i]) void'(q[i].pop_front());
        if (acc) q[m_lane].push_back(in_data);
        if (m_cyc % DWELL == DWELL - 1) begin
            if (d_off)      m_lane = int'(m_lfsr[2:1]);
            else if (m_rnd) m_lane = 0;
            else            m_lane = (m_lane + 1) % 4;
            m_rnd = d_off;
        end
        m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        adv();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = '0; d_off = 1'b0; in_data = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL reset_valid got %b want 0000", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
        checks++; if (cur_lane !== 2'd0) begin errors++; $display("FAIL reset_lane got %0d want 0", cur_lane); end
        checks++; if ({led2, led1, led0} !== 3'b000) begin errors++; $display("FAIL reset_leds got %b want 000", {led2, led1, led0}); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    endtask

    task automatic test_rotation();
        do_reset();
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = 64'(c + 1);
            #1;
            checks++; if (cur_lane !== 2'((c / DWELL) % 4)) begin errors++; $display("FAIL rot_lane c=%0d got %0d want %0d", c, cur_lane, (c / DWELL) % 4); end
            checks++; if ({led2, led1, led0} !== led_tab[(c / DWELL) % 4]) begin errors++; $display("FAIL rot_leds c=%0d got %b want %b", c, {led2, led1, led0}, led_tab[(c / DWELL) % 4]); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rot_ready c=%0d got %b want 1", c, in_ready); end
            checks++; if (out_valid !== m_valid()) begin errors++; $display("FAIL rot_valid c=%0d got %b want %b", c, out_valid, m_valid()); end
            // With all consumers ready, only the previous word is buffered.
            if (c > 0) begin
                checks++; if (out_data[((c - 1) / DWELL) % 4] !== 64'(c)) begin errors++; $display("FAIL rot_data c=%0d got %h want %h", c, out_data[((c - 1) / DWELL) % 4], 64'(c)); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int n_acc [4];
        do_reset();
        for (int i = 0; i < 4; i++) n_acc[i] = 0;
        out_ready = '0;
        in_valid  = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_data = {$urandom, $urandom};
            #1;
            checks++; if (in_ready !== ((c % DWELL) < DEPTH)) begin errors++; $display("FAIL bp_ready c=%0d got %b want %b", c, in_ready, (c % DWELL) < DEPTH); end
            if (in_ready) n_acc[cur_lane]++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (n_acc[i] != DEPTH) begin errors++; $display("FAIL bp_count lane=%0d got %0d want %0d", i, n_acc[i], DEPTH); end
        end
        in_valid  = 1'b0;
        out_ready = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (out_valid !== m_valid()) begin errors++; $display("FAIL bp_drain_valid c=%0d got %b want %b", c, out_valid, m_valid()); end
            if (q[0].size() > 0) begin
                checks++; if (out_data[0] !== q[0][0]) begin errors++; $display("FAIL bp_drain_data c=%0d got %h want %h", c, out_data[0], q[0][0]); end
            end
            tick();
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        in_valid = 1'b1;
        in_data  = 64'hA; tick();
        in_data  = 64'hB; tick();
        in_data  = 64'hC; out_ready = 4'b0001;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %b want 0", in_ready); end
        tick();
        out_ready = '0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_next_ready got %b want 1", in_ready); end
        checks++; if (out_data[0] !== 64'hB) begin errors++; $display("FAIL full_head1 got %h want b", out_data[0]); end
        tick();
        in_valid = 1'b0; out_ready = 4'b0001;
        tick();
        #1;
        checks++; if (out_data[0] !== 64'hC || out_valid[0] !== 1'b1) begin errors++; $display("FAIL full_head2 got %h/%b want c/1", out_data[0], out_valid[0]); end
        tick();
        #1;
        checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", out_valid[0]); end
    endtask

    task automatic test_random();
        do_reset();
        d_off = 1'b1;
        for (int c = 0; c < 68; c++) begin
            if (c == 64) d_off = 1'b0;
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = 4'($urandom);
            #1;
            checks++; if (cur_lane !== 2'(m_lane)) begin errors++; $display("FAIL rnd_lane c=%0d got %0d want %0d", c, cur_lane, m_lane); end
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, in_ready, m_ready()); end
            checks++; if (out_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, m_valid()); end
            for (int i = 0; i < 4; i++)
                if (q[i].size() > 0) begin
                    checks++; if (out_data[i] !== q[i][0]) begin errors++; $display("FAIL rnd_data c=%0d lane=%0d got %h want %h", c, i, out_data[i], q[i][0]); end
                end
            tick();
        end
        #1;
        checks++; if (cur_lane !== 2'd0) begin errors++; $display("FAIL rnd_back_seq got %0d want 0", cur_lane); end
    endtask

    task automatic test_doff_pulse();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            d_off = ((c % DWELL) == 1) || ((c % DWELL) == 2);
            #1;
            checks++; if (cur_lane !== 2'((c / DWELL) % 4)) begin errors++; $display("FAIL pulse_lane c=%0d got %0d want %0d", c, cur_lane, (c / DWELL) % 4); end
            tick();
        end
        d_off = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = 64'(c + 100);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0) begin errors++; $display("FAIL async_valid got %b want 0000", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b want 0", in_ready); end
        @(negedge clk);
        model_reset();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        d_off    = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++; if (cur_lane !== 2'(m_lane)) begin errors++; $display("FAIL async_lane c=%0d got %0d want %0d", c, cur_lane, m_lane); end
            tick();
        end
        d_off = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rotation();
        test_backpressure();
        test_full_pop();
        test_random();
        test_doff_pulse();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
